// File: rtl/reg_top_apb_block_1.sv
// ---------------------------------------------------------------------------
// reg_top_apb_block_1
//   APB slave register block. An APB front end turns each access phase into
//   a one-cycle internal request and acknowledges it one cycle later, which
//   gives exactly one wait state per transfer. The request feeds a slice of
//   four 32-bit software read/write registers. Each register also has its own
//   hardware update path:
//     0x0 REG1  no hardware write path
//     0x4 REG2  hardware load when pulse is high
//     0x8 REG3  hardware bitwise clear (next_value is the mask)
//     0xC REG4  hardware bitwise set   (next_value is the mask)
//   Any other address, including unaligned ones, is an error: writes are
//   dropped, reads return 0, and PSLVERR is raised together with PREADY.
//
// Ports
//   PCLK, PRESETn                  clock, asynchronous active-low reset
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA   APB request
//   PREADY/PSLVERR/PRDATA          APB response
//   clear                          interrupt clear (no sources, ignored)
//   interrupt, soft_rst_o          tied low
//   REGn_*__curr_value             register contents, straight from the flops
//   REGn_*__next_value / __pulse   hardware update inputs
// ---------------------------------------------------------------------------
module reg_top_apb_block_1 #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  output logic                  PREADY,
  output logic                  PSLVERR,
  output logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  clear,
  output logic                  interrupt,
  output logic                  soft_rst_o,
  output logic [DATA_WIDTH-1:0] REG1_HW_RO__FIELD_0__curr_value,
  input  logic [DATA_WIDTH-1:0] REG2_HW_RW__FIELD_0__next_value,
  input  logic                  REG2_HW_RW__FIELD_0__pulse,
  output logic [DATA_WIDTH-1:0] REG2_HW_RW__FIELD_0__curr_value,
  input  logic [DATA_WIDTH-1:0] REG3_HW_CLR__FIELD_0__next_value,
  input  logic                  REG3_HW_CLR__FIELD_0__pulse,
  output logic [DATA_WIDTH-1:0] REG3_HW_CLR__FIELD_0__curr_value,
  input  logic [DATA_WIDTH-1:0] REG4_HW_SET__FIELD_0__next_value,
  input  logic                  REG4_HW_SET__FIELD_0__pulse,
  output logic [DATA_WIDTH-1:0] REG4_HW_SET__FIELD_0__curr_value
);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic                  req;
  logic                  sw_wr;
  logic [3:0]            hit;
  logic                  miss;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [DATA_WIDTH-1:0] ack_rdata;
  logic                  ack_err;
  logic [DATA_WIDTH-1:0] reg1;
  logic [DATA_WIDTH-1:0] reg2;
  logic [DATA_WIDTH-1:0] reg3;
  logic [DATA_WIDTH-1:0] reg4;
  logic [DATA_WIDTH-1:0] reg2_base;
  logic [DATA_WIDTH-1:0] reg3_base;
  logic [DATA_WIDTH-1:0] reg4_base;

  // Interrupt clear and the strobes of the mask-driven registers have no job.
  logic unused_ok;
  assign unused_ok = ^{clear, REG3_HW_CLR__FIELD_0__pulse, REG4_HW_SET__FIELD_0__pulse};

  // Front-end FSM: state register
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) state <= IDLE;
    else          state <= state_nxt;
  end

  // Front-end FSM: next state and the one-cycle internal request
  always_comb begin
    state_nxt = state;
    req       = 1'b0;
    case (state)
      IDLE: begin
        if (PSEL && PENABLE) begin
          req       = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Full-width decode, so aliases and unaligned addresses all miss.
  always_comb begin
    hit[0] = (PADDR == ADDR_WIDTH'('h0));
    hit[1] = (PADDR == ADDR_WIDTH'('h4));
    hit[2] = (PADDR == ADDR_WIDTH'('h8));
    hit[3] = (PADDR == ADDR_WIDTH'('hC));
    miss   = ~|hit;
  end

  always_comb begin
    rd_data = '0;
    if (!PWRITE) begin
      case (1'b1)
        hit[0]:  rd_data = reg1;
        hit[1]:  rd_data = reg2;
        hit[2]:  rd_data = reg3;
        hit[3]:  rd_data = reg4;
        default: rd_data = '0;
      endcase
    end
  end

  assign sw_wr = req & PWRITE;

  // Software value first, hardware operation layered on top of it.
  always_comb begin
    reg2_base = (sw_wr && hit[1]) ? PWDATA : reg2;
    reg3_base = (sw_wr && hit[2]) ? PWDATA : reg3;
    reg4_base = (sw_wr && hit[3]) ? PWDATA : reg4;
  end

  // Register slice
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      reg1 <= '0;
      reg2 <= '0;
      reg3 <= '1;
      reg4 <= '0;
    end else begin
      if (sw_wr && hit[0]) reg1 <= PWDATA;
      reg2 <= REG2_HW_RW__FIELD_0__pulse ? REG2_HW_RW__FIELD_0__next_value : reg2_base;
      reg3 <= reg3_base & ~REG3_HW_CLR__FIELD_0__next_value;
      reg4 <= reg4_base | REG4_HW_SET__FIELD_0__next_value;
    end
  end

  // Ack stage: response captured at the request edge, held for the WAIT cycle
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      ack_rdata <= '0;
      ack_err   <= 1'b0;
    end else if (req) begin
      ack_rdata <= rd_data;
      ack_err   <= miss;
    end else begin
      ack_rdata <= '0;
      ack_err   <= 1'b0;
    end
  end

  assign PREADY     = (state == WAIT);
  assign PSLVERR    = ack_err;
  assign PRDATA     = ack_rdata;
  assign interrupt  = 1'b0;
  assign soft_rst_o = 1'b0;

  assign REG1_HW_RO__FIELD_0__curr_value  = reg1;
  assign REG2_HW_RW__FIELD_0__curr_value  = reg2;
  assign REG3_HW_CLR__FIELD_0__curr_value = reg3;
  assign REG4_HW_SET__FIELD_0__curr_value = reg4;

endmodule

// File: tb/tb_reg_top_apb_block_1.sv
// ---------------------------------------------------------------------------
// tb_reg_top_apb_block_1
//   Directed and randomized bench for reg_top_apb_block_1. A register-level
//   model (array of four words plus the expected bus response) is advanced
//   once per clock edge from the bus/hardware rules, and every DUT output is
//   compared on the falling edge.
// ---------------------------------------------------------------------------
module tb_reg_top_apb_block_1;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic        PSEL, PENABLE, PWRITE;
  logic [63:0] PADDR;
  logic [31:0] PWDATA;
  logic        PREADY, PSLVERR;
  logic [31:0] PRDATA;
  logic        clear;
  logic        interrupt, soft_rst_o;
  logic [31:0] cv1, cv2, cv3, cv4;
  logic [31:0] nv2, nv3, nv4;
  logic        p2, p3, p4;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [31:0] m [4];
  logic        e_ready, e_err;
  logic [31:0] e_rdata;

  logic [63:0] addrs [8];

  always #5 PCLK = ~PCLK;

  reg_top_apb_block_1 dut (
    .PCLK                            (PCLK),
    .PRESETn                         (PRESETn),
    .PSEL                            (PSEL),
    .PENABLE                         (PENABLE),
    .PWRITE                          (PWRITE),
    .PADDR                           (PADDR),
    .PWDATA                          (PWDATA),
    .PREADY                          (PREADY),
    .PSLVERR                         (PSLVERR),
    .PRDATA                          (PRDATA),
    .clear                           (clear),
    .interrupt                       (interrupt),
    .soft_rst_o                      (soft_rst_o),
    .REG1_HW_RO__FIELD_0__curr_value (cv1),
    .REG2_HW_RW__FIELD_0__next_value (nv2),
    .REG2_HW_RW__FIELD_0__pulse      (p2),
    .REG2_HW_RW__FIELD_0__curr_value (cv2),
    .REG3_HW_CLR__FIELD_0__next_value(nv3),
    .REG3_HW_CLR__FIELD_0__pulse     (p3),
    .REG3_HW_CLR__FIELD_0__curr_value(cv3),
    .REG4_HW_SET__FIELD_0__next_value(nv4),
    .REG4_HW_SET__FIELD_0__pulse     (p4),
    .REG4_HW_SET__FIELD_0__curr_value(cv4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("pready",    {31'b0, PREADY},     {31'b0, e_ready});
    chk("pslverr",   {31'b0, PSLVERR},    {31'b0, e_err});
    chk("prdata",    PRDATA,              e_rdata);
    chk("interrupt", {31'b0, interrupt},  32'h0);
    chk("soft_rst",  {31'b0, soft_rst_o}, 32'h0);
    chk("reg1",      cv1, m[0]);
    chk("reg2",      cv2, m[1]);
    chk("reg3",      cv3, m[2]);
    chk("reg4",      cv4, m[3]);
  endtask

  task automatic model_reset();
    m[0] = 32'h0; m[1] = 32'h0; m[2] = 32'hFFFF_FFFF; m[3] = 32'h0;
    e_ready = 1'b0; e_err = 1'b0; e_rdata = 32'h0;
  endtask

  // Advance the model across one rising edge; req marks the access-phase edge.
  task automatic cycle(input bit req);
    bit          valid;
    int          idx;
    logic [31:0] rd;
    valid = (PADDR == 64'h0) || (PADDR == 64'h4) || (PADDR == 64'h8) || (PADDR == 64'hC);
    idx   = int'(PADDR[3:2]);
    rd    = (req && valid && !PWRITE) ? m[idx] : 32'h0;
    if (req && valid && PWRITE) m[idx] = PWDATA;
    if (p2) m[1] = nv2;
    m[2] = m[2] & ~nv3;
    m[3] = m[3] | nv4;
    e_ready = req;
    e_err   = req && !valid;
    e_rdata = rd;
    @(posedge PCLK);
    @(negedge PCLK);
    check_all();
  endtask

  // Full APB transfer: setup, access (one wait state), then idle.
  task automatic apb(input logic [63:0] a, input bit wr, input logic [31:0] d);
    PSEL = 1'b1; PENABLE = 1'b0; PADDR = a; PWRITE = wr; PWDATA = d;
    cycle(1'b0);
    PENABLE = 1'b1;
    cycle(1'b1);
    PSEL = 1'b0; PENABLE = 1'b0;
    cycle(1'b0);
  endtask

  initial begin
    addrs = '{64'h0, 64'h4, 64'h8, 64'hC, 64'h10, 64'h2,
              64'h1_0000_0000, 64'hFFFF_FFFF_FFFF_FFFC};
    PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = 64'h0; PWDATA = 32'h0; clear = 1'b0;
    nv2 = 32'h0; nv3 = 32'h0; nv4 = 32'h0; p2 = 1'b0; p3 = 1'b0; p4 = 1'b0;
    model_reset();
    repeat (3) @(negedge PCLK);
    PRESETn = 1'b1;
    check_all();
    chk("rst_reg1", cv1, 32'h0000_0000);
    chk("rst_reg3", cv3, 32'hFFFF_FFFF);
    chk("rst_reg4", cv4, 32'h0000_0000);

    // SW write / read of REG1
    apb(64'h0, 1'b1, 32'h1234_5678);
    chk("reg1_wr", cv1, 32'h1234_5678);
    PSEL = 1'b1; PENABLE = 1'b0; PADDR = 64'h0; PWRITE = 1'b0;
    cycle(1'b0);
    PENABLE = 1'b1;
    cycle(1'b1);
    chk("reg1_rd", PRDATA, 32'h1234_5678);
    PSEL = 1'b0; PENABLE = 1'b0;
    cycle(1'b0);

    // REG2 hardware load with a single-cycle pulse
    nv2 = 32'h1234_5678; p2 = 1'b1;
    cycle(1'b0);
    p2 = 1'b0;
    chk("reg2_load", cv2, 32'h1234_5678);
    nv2 = 32'hDEAD_BEEF;
    cycle(1'b0);
    chk("reg2_hold", cv2, 32'h1234_5678);
    apb(64'h4, 1'b0, 32'h0);

    // Full masks on REG3/REG4
    nv3 = 32'hFFFF_FFFF; nv4 = 32'hFFFF_FFFF;
    cycle(1'b0);
    chk("reg3_clr", cv3, 32'h0000_0000);
    chk("reg4_set", cv4, 32'hFFFF_FFFF);
    nv3 = 32'h0; nv4 = 32'h0;
    apb(64'h8, 1'b1, 32'hFFFF_FFFF);
    nv3 = 32'h0000_00F0;
    cycle(1'b0);
    nv3 = 32'h0;
    chk("reg3_part", cv3, 32'hFFFF_FF0F);

    // Decode misses
    apb(64'h10, 1'b1, 32'hA5A5_A5A5);
    apb(64'h10, 1'b0, 32'h0);
    apb(64'h2,  1'b1, 32'h5A5A_5A5A);
    apb(64'h2,  1'b0, 32'h0);

    // SW write and HW set on REG4 in the same cycle: set wins on top
    nv4 = 32'h1;
    apb(64'hC, 1'b1, 32'h0);
    nv4 = 32'h0;
    chk("reg4_prio", cv4, 32'h0000_0001);

    // Reset in the WAIT cycle
    PSEL = 1'b1; PENABLE = 1'b0; PADDR = 64'h4; PWRITE = 1'b1; PWDATA = 32'hCAFE_F00D;
    cycle(1'b0);
    PENABLE = 1'b1;
    cycle(1'b1);
    PRESETn = 1'b0;
    #1;
    model_reset();
    check_all();
    PSEL = 1'b0; PENABLE = 1'b0;
    @(negedge PCLK);
    PRESETn = 1'b1;
    cycle(1'b0);

    // Randomized transfers with concurrent hardware activity
    for (int i = 0; i < 60; i++) begin
      nv2 = $urandom; p2 = ($urandom_range(0, 3) == 0);
      nv3 = $urandom & $urandom & $urandom;
      nv4 = $urandom & $urandom & $urandom;
      apb(addrs[$urandom_range(0, 7)], bit'($urandom_range(0, 1)), $urandom);
    end
    nv2 = 32'h0; p2 = 1'b0; nv3 = 32'h0; nv4 = 32'h0;
    cycle(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
